// File: rtl/se_sram_req_adapter_if.sv
// Request/response valid-ready bundle between a requester and se_sram_req_adapter.
// The requester uses the master modport and the adapter uses the slave modport.
interface se_sram_req_adapter_if #(
  parameter int address_width = 16,
  parameter int data_width    = 8
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_read_not_write;
  logic [address_width-1:0] req_address;
  logic [data_width-1:0]    req_write_data;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [data_width-1:0]    rsp_data;

  modport master (
    output req_valid, req_read_not_write, req_address, req_write_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_read_not_write, req_address, req_write_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/se_sram_req_adapter.sv
// Valid/ready front-end for a single-port SRAM with a registered read output.
// Read data is captured one cycle after the read into a 3-entry response FIFO.
module se_sram_req_adapter #(
  parameter int address_width = 16,
  parameter int data_width    = 8
) (
  input  logic                     sram_clock,
  input  logic                     reset_n,
  input  logic                     sram_clock__enable,
  se_sram_req_adapter_if.slave     bus,
  output logic                     sram_select,
  output logic                     sram_read_not_write,
  output logic                     sram_write_enable,
  output logic [address_width-1:0] sram_address,
  output logic [data_width-1:0]    sram_write_data,
  input  logic [data_width-1:0]    sram_data_out
);

  logic                  r_inflight;
  logic [1:0]            r_rd_ptr;
  logic [1:0]            r_wr_ptr;
  logic [1:0]            r_occupancy;
  logic [data_width-1:0] r_mem [3];

  logic [2:0] w_committed;
  logic       w_req_ready;
  logic       w_accept;
  logic       w_rsp_valid;
  logic       w_push;
  logic       w_pop;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Ready looks only at registered state, so rsp_ready never reaches req_ready.
  assign w_committed = {1'b0, r_occupancy} + {2'b00, r_inflight};
  assign w_req_ready = sram_clock__enable && (w_committed < 3'd3);
  assign w_accept    = bus.req_valid && w_req_ready;
  assign w_rsp_valid = (r_occupancy != 2'd0);
  assign w_push      = sram_clock__enable && r_inflight;
  assign w_pop       = sram_clock__enable && w_rsp_valid && bus.rsp_ready;

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_data  = r_mem[r_rd_ptr];

  assign sram_select         = w_accept;
  assign sram_read_not_write = bus.req_read_not_write;
  assign sram_write_enable   = w_accept && !bus.req_read_not_write;
  assign sram_address        = bus.req_address;
  assign sram_write_data     = bus.req_write_data;

  always_ff @(posedge sram_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_inflight  <= 1'b0;
      r_rd_ptr    <= 2'd0;
      r_wr_ptr    <= 2'd0;
      r_occupancy <= 2'd0;
      for (int i = 0; i < 3; i++) r_mem[i] <= '0;
    end else if (sram_clock__enable) begin
      r_inflight <= w_accept && bus.req_read_not_write;
      if (w_push) begin
        r_mem[r_wr_ptr] <= sram_data_out;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_occupancy <= r_occupancy + 2'd1;
        2'b01:   r_occupancy <= r_occupancy - 2'd1;
        default: r_occupancy <= r_occupancy;
      endcase
    end
  end

endmodule

// File: tb/tb_se_sram_req_adapter.sv
// Directed bench for se_sram_req_adapter with a behavioural registered-output SRAM.
module tb_se_sram_req_adapter;
  logic        clk;
  logic        rst_n;
  logic        en;
  logic        sram_select, sram_rnw, sram_we;
  logic [15:0] sram_address;
  logic [7:0]  sram_wdata;
  logic [7:0]  sram_dout;
  logic [7:0]  mem [0:255];

  int errors = 0;
  int checks = 0;

  se_sram_req_adapter_if #(.address_width(16), .data_width(8)) bus ();

  se_sram_req_adapter #(.address_width(16), .data_width(8)) dut (
    .sram_clock          (clk),
    .reset_n             (rst_n),
    .sram_clock__enable  (en),
    .bus                 (bus),
    .sram_select         (sram_select),
    .sram_read_not_write (sram_rnw),
    .sram_write_enable   (sram_we),
    .sram_address        (sram_address),
    .sram_write_data     (sram_wdata),
    .sram_data_out       (sram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: output register only updates on enabled, selected reads
  always @(posedge clk) begin
    if (en && sram_select) begin
      if (sram_we) mem[sram_address[7:0]] <= sram_wdata;
      else if (sram_rnw) sram_dout <= mem[sram_address[7:0]];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rnw, input logic [15:0] a,
                       input logic [7:0] d, input logic rr);
    bus.req_valid          = v;
    bus.req_read_not_write = rnw;
    bus.req_address        = a;
    bus.req_write_data     = d;
    bus.rsp_ready          = rr;
    #1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int exp_rdy3 [6] = '{1, 1, 1, 0, 0, 1};
  int exp_rv3  [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
  int exp_d3   [9] = '{0, 0, 8'h10, 8'h10, 8'h10, 8'h11, 8'h12, 8'h13, 0};
  logic [7:0] exp_q [$];
  int nreq;
  int nrsp;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    sram_dout = 8'h00;
    rst_n = 1'b0;
    en    = 1'b1;
    bus.req_valid = 1'b0; bus.req_read_not_write = 1'b0;
    bus.req_address = '0; bus.req_write_data = '0; bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    cyc();

    // reset state
    drive(0, 0, 16'h0, 8'h0, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_select", sram_select, 0);
    chk("rst_we", sram_we, 0);
    en = 1'b0; #1;
    chk("rst_ready_en_low", bus.req_ready, 0);
    en = 1'b1;
    cyc();

    // write then read same address
    drive(1, 0, 16'h0010, 8'hA5, 1);
    chk("t1_wr_ready", bus.req_ready, 1);
    chk("t1_wr_select", sram_select, 1);
    chk("t1_wr_we", sram_we, 1);
    cyc();
    drive(1, 1, 16'h0010, 8'h00, 1);
    chk("t1_rd_select", sram_select, 1);
    chk("t1_rd_we", sram_we, 0);
    chk("t1_rd_rnw", sram_rnw, 1);
    cyc();
    drive(0, 0, 16'h0, 8'h0, 1);
    chk("t1_n1_rsp_valid", bus.rsp_valid, 0);
    chk("t1_n1_select", sram_select, 0);
    cyc();
    chk("t1_n2_rsp_valid", bus.rsp_valid, 1);
    chk("t1_n2_rsp_data", bus.rsp_data, 8'hA5);
    cyc();
    chk("t1_single_rsp", bus.rsp_valid, 0);

    // back-to-back reads
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 16'(i), 8'(8'h10 + i), 1);
      chk("t2_pre_ready", bus.req_ready, 1);
      cyc();
    end
    for (int k = 0; k < 6; k++) begin
      drive(k < 4, 1, 16'(k), 8'h0, 1);
      if (k < 4) chk("t2_ready", bus.req_ready, 1);
      if (k < 2) chk("t2_rsp_idle", bus.rsp_valid, 0);
      else begin
        chk("t2_rsp_valid", bus.rsp_valid, 1);
        chk("t2_rsp_data", bus.rsp_data, 32'(8'h10 + k - 2));
      end
      cyc();
    end
    chk("t2_drained", bus.rsp_valid, 0);

    // backpressure
    for (int k = 0; k < 9; k++) begin
      drive(k <= 5, 1, 16'((k < 3) ? k : 3), 8'h0, k >= 4);
      if (k <= 5) chk("t3_ready", bus.req_ready, 32'(exp_rdy3[k]));
      chk("t3_rsp_valid", bus.rsp_valid, 32'(exp_rv3[k]));
      if (exp_rv3[k] == 1) chk("t3_rsp_data", bus.rsp_data, 32'(exp_d3[k]));
      cyc();
    end

    // clock-enable gap
    drive(1, 0, 16'h0004, 8'h14, 1);
    cyc();
    drive(1, 1, 16'h0004, 8'h00, 1);
    chk("t4_accept_ready", bus.req_ready, 1);
    cyc();
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 16'h0000, 8'h00, 1);
      chk("t4_gap_ready", bus.req_ready, 0);
      chk("t4_gap_select", sram_select, 0);
      chk("t4_gap_rsp_valid", bus.rsp_valid, 0);
      cyc();
    end
    en = 1'b1;
    drive(0, 0, 16'h0, 8'h0, 1);
    chk("t4_reen_rsp_valid", bus.rsp_valid, 0);
    cyc();
    chk("t4_rsp_valid", bus.rsp_valid, 1);
    chk("t4_rsp_data", bus.rsp_data, 8'h14);
    cyc();
    chk("t4_drained", bus.rsp_valid, 0);

    // reset with one read in flight and two queued
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 16'(k), 8'h0, 0);
      chk("t5_ready", bus.req_ready, 1);
      cyc();
    end
    drive(0, 0, 16'h0, 8'h0, 0);
    chk("t5_pre_rsp_valid", bus.rsp_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_rsp_valid", bus.rsp_valid, 0);
    chk("t5_async_rsp_data", bus.rsp_data, 0);
    chk("t5_async_ready", bus.req_ready, 1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    cyc();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 16'h0, 8'h0, 1);
      chk("t5_no_stale", bus.rsp_valid, 0);
      cyc();
    end

    // push+pop at occupancy 2 and pointer wrap over 10 reads
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 16'(i), 8'(8'h30 + i), 0);
      cyc();
    end
    nreq = 0;
    nrsp = 0;
    for (int k = 0; k < 80 && nrsp < 10; k++) begin
      drive(nreq < 10, 1, 16'(nreq), 8'h0, (k >= 3) && (k % 3 != 2));
      if (k == 3) begin
        chk("t6_occ2_ready", bus.req_ready, 0);
        chk("t6_occ2_head", bus.rsp_data, 8'h30);
      end
      if (k == 4) begin
        chk("t6_after_pushpop_ready", bus.req_ready, 1);
        chk("t6_after_pushpop_head", bus.rsp_data, 8'h31);
        chk("t6_after_pushpop_valid", bus.rsp_valid, 1);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) chk("t6_spurious_rsp", 1, 0);
        else chk("t6_order", bus.rsp_data, exp_q.pop_front());
        nrsp++;
      end
      if (bus.req_valid && bus.req_ready) begin
        exp_q.push_back(8'(8'h30 + nreq));
        nreq++;
      end
      cyc();
    end
    chk("t6_rsp_count", nrsp, 10);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 16'h0, 8'h0, 1);
      chk("t6_no_extra", bus.rsp_valid, 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/se_sram_req_adapter.md
# se_sram_req_adapter

Valid/ready request front-end for a single-port `se_sram_srw` instance. It sits directly upstream of the SRAM: it accepts read and write requests, drives the SRAM port, and captures read data into a 3-entry response FIFO. Responses are presented on a valid/ready interface with full one-read-per-cycle throughput and no combinational path from `rsp_ready` to `req_ready`.

## Interface
Parameters:
- `address_width`, default 16: SRAM address width.
- `data_width`, default 8: SRAM data width.

Ports:
- `sram_clock`  in  1  single clock for the block and the attached SRAM.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sram_clock__enable`  in  1  clock enable. When low, no state changes, no request is accepted and no response is popped.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted this cycle when `req_valid && req_ready`.
- `req_read_not_write`  in  1  1 means read, 0 means write.
- `req_address`  in  address_width  request address.
- `req_write_data`  in  data_width  write data.
- `rsp_valid`  out  1  read response available.
- `rsp_ready`  in  1  consumer takes the response when `rsp_valid && rsp_ready`.
- `rsp_data`  out  data_width  read data (head of the FIFO).
- `sram_select`  out  1  to the SRAM `select` input.
- `sram_read_not_write`  out  1  to the SRAM `read_not_write` input.
- `sram_write_enable`  out  1  to the SRAM `write_enable` input.
- `sram_address`  out  address_width  to the SRAM `address` input.
- `sram_write_data`  out  data_width  to the SRAM `write_data` input.
- `sram_data_out`  in  data_width  from the SRAM `data_out` output.

## Operation
Internal state:
- `inflight`: 1 bit. Set when a read is accepted; the read data lands in the SRAM output register on that edge.
- 3-entry FIFO with 2-bit read and write pointers that wrap 2→0.
- `occupancy`: 0..3.

Request side:
- `req_ready = sram_clock__enable && (occupancy + inflight < 3)`. The condition is registered-state only and independent of `req_valid` and `req_read_not_write`.
- `accept = req_valid && req_ready`.

SRAM drive (combinational):
- `sram_select = accept`.
- `sram_read_not_write = req_read_not_write`.
- `sram_write_enable = accept && !req_read_not_write`.
- `sram_address` and `sram_write_data` pass through from the request.
- When `accept` is 0, `sram_select` and `sram_write_enable` are 0.

Update on each enabled edge:
- `inflight <= accept && req_read_not_write`.
- Push when `inflight` is 1: write `sram_data_out` into the FIFO.
- Pop when `rsp_valid && rsp_ready`.
- Push and pop in the same cycle are both performed; `occupancy` is unchanged.

Response side:
- `rsp_valid = (occupancy != 0)`.
- `rsp_data` = entry at the read pointer.

Ordering and behaviour rules:
- Writes produce no response.
- The SRAM executes requests in acceptance order, so a read after a write to the same address returns the new data.
- Overflow cannot occur, because `req_ready` reserves a slot for every in-flight read.

Enable and reset:
- Enable low while `inflight` = 1: the SRAM output holds, because it only updates on enabled reads. The capture therefore happens on the next enabled edge.
- `reset_n` low, asynchronous and at any time, including mid-burst: `inflight` = 0, pointers = 0, `occupancy` = 0, FIFO contents = 0.
- After reset:
  - `rsp_valid` = 0 and `rsp_data` = 0.
  - `req_ready` = `sram_clock__enable`.
  - SRAM strobes are 0 unless a new request is accepted.
- A read accepted before reset produces no response.

## Timing
- Read accepted in cycle N:
  - The SRAM registers the read at the end of N.
  - `sram_data_out` is valid in N+1 and is captured at the end of N+1.
  - `rsp_valid` is 1 in N+2, a latency of 2 enabled cycles.
- Steady state with `rsp_ready` = 1: one read accepted and one response delivered per cycle (`occupancy` ≤ 1, `inflight` = 1).
- With `rsp_ready` held 0: at most 3 reads are accepted before `req_ready` drops. It drops in the cycle where `occupancy + inflight` = 3.
- After a pop frees a slot, `req_ready` rises in the following cycle.
- Writes complete at the end of their accept cycle. `req_ready` governs writes the same way it governs reads.

## Test plan
- **Write then read:** write 0xA5 to address 0x0010, then read 0x0010 in the next cycle. Expect `rsp_valid` 2 cycles after the read is accepted, with `rsp_data` = 0xA5 and exactly one response.
- **Back-to-back reads:** preload addresses 0..3 with 0x10..0x13 and issue 4 consecutive reads with `rsp_ready` = 1. Expect `req_ready` to stay 1 and the responses 0x10, 0x11, 0x12, 0x13 on 4 consecutive cycles starting 2 cycles after the first accept.
- **Backpressure:** with `rsp_ready` = 0, hold `req_valid` high for reads. Expect exactly 3 accepts, then `req_ready` = 0, then `occupancy` = 3. Raise `rsp_ready`: the 3 responses drain in order, and the 4th read is accepted the cycle after the first pop.
- **Clock-enable gap:** accept a read, then drop `sram_clock__enable` for 3 cycles. Expect no state change and `req_ready` = 0 during the gap. The response appears 1 enabled cycle after re-enable plus one edge, with the correct data.
- **Reset mid-operation:** assert `reset_n` low asynchronously with 1 read in flight and 2 entries queued. Expect `rsp_valid` = 0 immediately, and no stale responses after release.
- **Simultaneous push and pop at `occupancy` 2:** expect `occupancy` to stay at 2, data order preserved, and the pointers wrapping from 2 to 0 correctly over 10 consecutive reads.
